pipeline_sequencer: RTL
=======================

// Module: pipeline_sequencer
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Merges the load-use/branch stall request, the
//  taken-branch redirect and the instruction/data memory req/ack handshakes into per-stage write enables
//  and flush controls. Contains a boot sequence, a data-memory wait FSM with timeout, and saturating
//  stall/flush event counters. Sits beside the hazard detector and drives PC, IFToID, IDToEx, ExToMem
//  and MemToWB.
// PARAMETERS
//  BOOT_CYCLES  2   cycles held in BOOT after reset release (1..15)
//  MAX_WAIT     16  memory-wait cycles without ack before ERROR (2..255)
//  CNT_WIDTH    16  width of the stall/flush event counters
// PORTS
//  clk_i            in   1          clock, rising edge
//  rst_i            in   1          asynchronous reset, active-high
//  stall_req_i      in   1          stall request from the hazard detector
//  branch_taken_i   in   1          branch in ID resolved taken; PC source selected externally
//  imem_ack_i       in   1          instruction word valid this cycle
//  dmem_op_i        in   1          instruction in ExToMem is lw/sw
//  dmem_ack_i       in   1          data memory completes the access this cycle
//  imem_req_o       out  1          fetch request
//  dmem_req_o       out  1          data memory request
//  pc_write_o       out  1          PC load enable
//  if_id_write_o    out  1          IFToID load enable
//  if_id_flush_o    out  1          IFToID clear (takes effect only when if_id_write_o=1)
//  id_ex_write_o    out  1          IDToEx load enable
//  id_ex_flush_o    out  1          load a bubble (all ctrl 0) into IDToEx
//  ex_mem_write_o   out  1          ExToMem load enable
//  mem_wb_write_o   out  1          MemToWB load enable
//  error_o          out  1          sticky memory-timeout flag
//  stall_cnt_o      out  CNT_WIDTH  PC-frozen cycles counted in RUN/DMEM_WAIT, saturating
//  flush_cnt_o      out  CNT_WIDTH  if_id_flush_o pulses, saturating
// BEHAVIOUR
//  Reset (async): state=BOOT, boot/wait counters=0, error_o=0, both event counters=0. All outputs are 0
//   during reset and in BOOT.
//  State register, counters and error_o are registered. All other outputs are combinational from the
//   current state and the inputs (zero latency).
//  BOOT: every enable, flush and request is 0. Moves to RUN after BOOT_CYCLES cycles.
//  RUN: imem_req_o=1 and dmem_req_o=dmem_op_i. Rules are evaluated in priority order; all unlisted
//   enables are 1 and flushes are 0.
//   1. dmem_op_i and !dmem_ack_i: every *_write_o=0 (full freeze). Next state DMEM_WAIT, wait_cnt=1.
//   2. stall_req_i: pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1. A branch_taken_i in the same cycle is
//      ignored; it is re-presented by the hazard detector next cycle.
//   3. branch_taken_i: pc_write_o=1, if_id_flush_o=1. This holds regardless of imem_ack_i; the
//      outstanding fetch is abandoned and re-issued next cycle at the new PC.
//   4. !imem_ack_i: pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1; the back end keeps advancing.
//      imem_wait_cnt increments. It clears when imem_ack_i=1 or when rule 3 fires.
//   5. Otherwise all enables are 1.
//  DMEM_WAIT: imem_req_o=1 and dmem_req_o=1. All writes stay 0 until dmem_ack_i.
//   On the dmem_ack_i cycle: ex_mem_write_o=1 and mem_wb_write_o=1, and the front end follows RUN
//   rules 2-5. Next state RUN.
//   Without an ack, wait_cnt increments. When wait_cnt reaches MAX_WAIT, the next state is ERROR.
//  IMEM timeout: if imem_wait_cnt reaches MAX_WAIT in RUN, the next state is ERROR.
//  ERROR: error_o=1; all enables, flushes and requests are 0. Only rst_i leaves ERROR.
//  Counters: stall_cnt_o increments on each RUN/DMEM_WAIT cycle with pc_write_o=0. flush_cnt_o
//   increments on each cycle with if_id_flush_o=1. Both hold at 2^CNT_WIDTH-1. An async reset
//   mid-wait returns immediately to BOOT and clears everything.
//  Flush/write pairing: id_ex_flush_o=1 always comes with id_ex_write_o=1.
// TESTING
//  1 rst_i pulse, then idle inputs with imem_ack_i=1 -> outputs 0 for 2 cycles, then all enables 1 and
//    imem_req_o=1 on cycle 3.
//  2 stall_req_i=1 and branch_taken_i=1 for 1 cycle in RUN -> pc_write_o=0, if_id_write_o=0,
//    id_ex_flush_o=1, if_id_flush_o=0; stall_cnt_o +1.
//  3 dmem_op_i=1, dmem_ack_i delayed 3 cycles -> 3 cycles of all writes 0 with dmem_req_o=1; on the ack
//    cycle ex_mem_write_o=mem_wb_write_o=1; stall_cnt_o=3.
//  4 dmem_op_i=1, no ack for 16 cycles -> ERROR: error_o=1, all outputs 0; stays there until rst_i.
//  5 imem_ack_i=0 for 2 cycles, then branch_taken_i=1 -> 2 bubble cycles, then pc_write_o=1,
//    if_id_flush_o=1, flush_cnt_o=1.
//  6 CNT_WIDTH=4 with 20 stall cycles -> stall_cnt_o saturates at 15; async reset mid-DMEM_WAIT -> BOOT
//    with counters 0.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: boot hold, data-memory
// wait with timeout, fetch-wait bubbles and saturating event counters.
//
// state     | meaning
// BOOT      | post-reset hold, every enable/request low
// RUN       | normal issue; front-end rules applied in priority order
// DMEM_WAIT | whole pipe frozen until the data memory acks
// ERROR     | memory timeout, everything low, sticky until reset
module pipeline_sequencer #(
    parameter int unsigned BOOT_CYCLES = 2,
    parameter int unsigned MAX_WAIT    = 16,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stall_req_i,
    input  logic                 branch_taken_i,
    input  logic                 imem_ack_i,
    input  logic                 dmem_op_i,
    input  logic                 dmem_ack_i,
    output logic                 imem_req_o,
    output logic                 dmem_req_o,
    output logic                 pc_write_o,
    output logic                 if_id_write_o,
    output logic                 if_id_flush_o,
    output logic                 id_ex_write_o,
    output logic                 id_ex_flush_o,
    output logic                 ex_mem_write_o,
    output logic                 mem_wb_write_o,
    output logic                 error_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {BOOT, RUN, DMEM_WAIT, ERROR} state_t;

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);
    localparam logic [7:0] MAX_W     = 8'(MAX_WAIT);

    state_t               state_q, state_d;
    logic [3:0]           boot_cnt_q, boot_cnt_d;
    logic [7:0]           wait_cnt_q, wait_cnt_d;
    logic [7:0]           imem_cnt_q, imem_cnt_d;
    logic                 error_q, error_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    logic       fe_pc_w, fe_ifid_w, fe_ifid_f, fe_idex_f, fe_timeout;
    logic [7:0] fe_imem_cnt;

    // Front-end rules (stall > branch > fetch wait > normal), shared by RUN and the DMEM ack cycle
    always_comb begin
        fe_pc_w     = 1'b1;
        fe_ifid_w   = 1'b1;
        fe_ifid_f   = 1'b0;
        fe_idex_f   = 1'b0;
        fe_imem_cnt = imem_cnt_q;
        if (stall_req_i) begin
            fe_pc_w   = 1'b0;
            fe_ifid_w = 1'b0;
            fe_idex_f = 1'b1;
        end else if (branch_taken_i) begin
            fe_ifid_f   = 1'b1;
            fe_imem_cnt = 8'd0;
        end else if (!imem_ack_i) begin
            fe_pc_w     = 1'b0;
            fe_ifid_w   = 1'b0;
            fe_idex_f   = 1'b1;
            fe_imem_cnt = imem_cnt_q + 8'd1;
        end else begin
            fe_imem_cnt = 8'd0;
        end
        fe_timeout = (fe_imem_cnt == MAX_W);
    end

    // Next-state and output decode
    always_comb begin
        state_d        = state_q;
        boot_cnt_d     = boot_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        imem_cnt_d     = imem_cnt_q;
        error_d        = error_q;
        imem_req_o     = 1'b0;
        dmem_req_o     = 1'b0;
        pc_write_o     = 1'b0;
        if_id_write_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_write_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_write_o = 1'b0;
        mem_wb_write_o = 1'b0;
        unique case (state_q)
            BOOT: begin
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d    = RUN;
                    boot_cnt_d = 4'd0;
                end else begin
                    boot_cnt_d = boot_cnt_q + 4'd1;
                end
            end
            RUN: begin
                imem_req_o = 1'b1;
                dmem_req_o = dmem_op_i;
                if (dmem_op_i && !dmem_ack_i) begin
                    state_d    = DMEM_WAIT;
                    wait_cnt_d = 8'd1;
                end else begin
                    pc_write_o     = fe_pc_w;
                    if_id_write_o  = fe_ifid_w;
                    if_id_flush_o  = fe_ifid_f;
                    id_ex_write_o  = 1'b1;
                    id_ex_flush_o  = fe_idex_f;
                    ex_mem_write_o = 1'b1;
                    mem_wb_write_o = 1'b1;
                    imem_cnt_d     = fe_imem_cnt;
                    if (fe_timeout) begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            DMEM_WAIT: begin
                imem_req_o = 1'b1;
                dmem_req_o = 1'b1;
                if (dmem_ack_i) begin
                    pc_write_o     = fe_pc_w;
                    if_id_write_o  = fe_ifid_w;
                    if_id_flush_o  = fe_ifid_f;
                    id_ex_write_o  = 1'b1;
                    id_ex_flush_o  = fe_idex_f;
                    ex_mem_write_o = 1'b1;
                    mem_wb_write_o = 1'b1;
                    imem_cnt_d     = fe_imem_cnt;
                    wait_cnt_d     = 8'd0;
                    state_d        = RUN;
                    if (fe_timeout) begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (wait_cnt_d == MAX_W) begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            ERROR: error_d = 1'b1;
            default: state_d = BOOT;
        endcase
    end

    // Saturating event counters; PC-frozen cycles only count while issuing or waiting
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((state_q == RUN || state_q == DMEM_WAIT) && !pc_write_o && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (if_id_flush_o && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    // State, counter and error registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= BOOT;
            boot_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            imem_cnt_q  <= '0;
            error_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            imem_cnt_q  <= imem_cnt_d;
            error_q     <= error_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign error_o     = error_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule
